// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle CPU I/O responder: register map,
// STATUS bit positions and the output-buffer state encoding.
package sc_io_pkg;

    // Default address bit that selects the I/O window.
    localparam int IO_SEL_BIT_DEFAULT = 7;

    // Register index, taken from addr[3:2] inside the I/O window.
    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;

    // STATUS register bit positions.
    localparam int ST_FULL = 0;
    localparam int ST_CHG  = 1;
    localparam int ST_OVF  = 2;

    // Output buffer state; the encoding doubles as out_valid.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sc_io_debounce.sv
// Two-flop synchroniser followed by a debounce counter. A synchronised value
// that differs from the accepted value for DEBOUNCE_CYCLES consecutive edges
// is accepted; returning to the accepted value restarts the count.
module sc_io_debounce #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic             accept_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Synchronise the asynchronous board inputs into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the two synchroniser stages into one.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count edges on which the synchronised value disagrees with the accepted one.
    // NOTE: every output of this block is given a default first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accepted value and debounce counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign accept_o = accept;

endmodule

// File: rtl/sc_io_responder.sv
// Memory-mapped I/O target for the single-cycle CPU data bus. Holds a
// one-word output buffer with a valid/ready handshake, two sticky status
// flags, and the combinational read mux; the input port is debounced by
// sc_io_debounce.
module sc_io_responder
    import sc_io_pkg::*;
#(
    parameter int IO_SEL_BIT      = IO_SEL_BIT_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        io_sel,
    input  logic [31:0] in_port,
    output logic [31:0] out_port,
    output logic        out_valid,
    input  logic        out_ready
);

    out_state_e  state_q, state_d;
    logic [31:0] out_data_q, out_data_d;
    logic        chg_q, chg_d;
    logic        ovf_q, ovf_d;
    logic        ovf_set;

    logic [1:0]  reg_idx;
    logic        wr_out, wr_stat;
    logic [31:0] in_stable;
    logic        in_accept;
    logic        unused_addr;

    // Only the window-select bit and addr[3:2] decode; other bits alias.
    assign unused_addr = ^addr;

    assign io_sel  = addr[IO_SEL_BIT];
    assign reg_idx = addr[3:2];
    assign wr_out  = we && io_sel && (reg_idx == REG_OUT);
    assign wr_stat = we && io_sel && (reg_idx == REG_STAT);

    sc_io_debounce #(
        .WIDTH          (32),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .raw_i   (in_port),
        .stable_o(in_stable),
        .accept_o(in_accept)
    );

    // Output buffer next state: accept a store when empty or being taken,
    // drop it (flagging overflow) when full and stalled, else drain on take.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        ovf_set    = 1'b0;
        if (wr_out) begin
            if (state_q == OUT_EMPTY || out_ready) begin
                out_data_d = wdata;
                state_d    = OUT_FULL;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (state_q == OUT_FULL && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    // Sticky flags: write-1-to-clear, with a same-edge set taking priority.
    always_comb begin
        chg_d = chg_q;
        ovf_d = ovf_q;
        if (wr_stat && wdata[ST_CHG]) chg_d = 1'b0;
        if (wr_stat && wdata[ST_OVF]) ovf_d = 1'b0;
        if (in_accept) chg_d = 1'b1;
        if (ovf_set)   ovf_d = 1'b1;
    end

    // Output buffer, handshake state and sticky flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OUT_EMPTY;
            out_data_q <= '0;
            chg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            chg_q      <= chg_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_port  = out_data_q;
    assign out_valid = (state_q == OUT_FULL);

    // Side-effect-free read mux; zero outside the I/O window.
    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (reg_idx)
                REG_OUT:  rdata = out_data_q;
                REG_IN:   rdata = in_stable;
                REG_STAT: begin
                    rdata[ST_FULL] = out_valid;
                    rdata[ST_CHG]  = chg_q;
                    rdata[ST_OVF]  = ovf_q;
                end
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/sc_io_responder.md
Name: sc_io_responder

Overview:
Memory-mapped I/O responder on the single-cycle CPU data bus: the target end of the CPU's load/store interface for the I/O address window. It holds an output buffer with a valid/ready handshake toward board peripherals, and debounces and synchronises the raw input port. The data memory wrapper uses io_sel to route stores and read data here instead of RAM.

Parameters:
IO_SEL_BIT, 7, address bit that selects I/O space (addr[IO_SEL_BIT]=1 -> this block)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new in_port value (>=2)
CNT_W, 5, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
addr  in  32  CPU byte address (ALU result)
wdata  in  32  CPU store data
we  in  1  CPU store enable; commits at rising edge
rdata  out  32  combinational read data
io_sel  out  1  addr[IO_SEL_BIT]; combinational
in_port  in  32  raw asynchronous board inputs (switches/keys)
out_port  out  32  buffered output word
out_valid  out  1  out_port holds an untaken word
out_ready  in  1  consumer accepts word

Behaviour:
- Register map (addr[3:2] when io_sel=1): 0 OUT_DATA (W; reads return out_port), 1 IN_DATA (R; debounced value), 2 STATUS (R/W1C), 3 reserved (reads 0, writes ignored).
- STATUS: bit0 out_full (=out_valid), bit1 in_changed (sticky), bit2 ovf (sticky); bits 31:3 read 0. Writing 1 to bit1/bit2 clears that bit; bit0 is read-only.
- rdata: combinational from addr and current registers; 0 when io_sel=0. Reads have no side effects.
- Reset values: out_port=0, out_valid=0, stable IN value=0, sync flops=0, debounce count=0, in_changed=0, ovf=0.
- Output FSM (EMPTY/FULL, state = out_valid):
  - take = out_valid & out_ready at the edge.
  - wr = we & io_sel & OUT_DATA selected.
  - accept = wr & (!out_valid | out_ready).
  - accept: out_port<=wdata, out_valid<=1 (this covers a store coinciding with take: the word is replaced and valid stays 1).
  - take & !wr: out_valid<=0; out_port holds its last value.
  - wr & out_valid & !out_ready: write dropped, out_port unchanged, ovf<=1.
  - out_port is stable while out_valid=1 and out_ready=0.
- Input path: 2-flop synchroniser on in_port, then debounce.
  - If sync == stable: count<=0.
  - Else if count == DEBOUNCE_CYCLES-1: stable<=sync, count<=0, in_changed<=1.
  - Else: count<=count+1.
  - Any sync value that differs from stable counts toward acceptance, even if it wiggles between different values; the value captured is sync at the accepting edge.
  - Latency: an in_port change held steady appears on IN_DATA after 2 + DEBOUNCE_CYCLES edges.
  - A return to stable before acceptance restarts the count.
- Simultaneous events on the same edge:
  - W1C of in_changed and a new acceptance: set wins (in_changed=1).
  - W1C of ovf and a new overflow: set wins.
- Reset asserted mid-transfer: out_valid drops on the next edge, the word is lost, and stickies clear; the consumer must not count a take in the reset cycle.
- Stores with io_sel=0 are ignored. Address bits other than IO_SEL_BIT and [3:2] are don't-care (window aliases).

Decomposition:
- Shared package sc_io_pkg:
  - Register index constants: REG_OUT=0, REG_IN=1, REG_STAT=2.
  - STATUS bit positions: ST_FULL=0, ST_CHG=1, ST_OVF=2.
  - Default IO_SEL_BIT.
- Sub-module sc_io_debounce (parameterised width/DEBOUNCE_CYCLES):
  - Contains the synchroniser, counter and stable register.
  - Outputs stable value and a one-cycle accept pulse.
- The top of this block holds the output FSM, the stickies and the read mux.

Test Plan:
1. Reset, then store 0x12345678 to 0x80 with out_ready=0 -> next cycle out_valid=1, out_port=0x12345678, STATUS read at 0x88 = 0x1.
2. While full with out_ready=0, store 0xDEADBEEF to 0x80 -> out_port stays 0x12345678, STATUS=0x5. Store 0x4 to 0x88 -> STATUS=0x1.
3. out_valid=1 and out_ready=1 on the same edge as a store of 0xCAFEF00D -> out_valid stays 1, out_port=0xCAFEF00D, no ovf. Next edge with ready=1 and no store -> out_valid=0.
4. in_port 0 -> 0x000000A5, held -> IN_DATA (0x84) reads 0 through edge 17 and reads 0xA5 after edge 18 (DEBOUNCE_CYCLES=16). STATUS bit1=1; store 0x2 to 0x88 clears it.
5. in_port glitch to 0xFF for 10 cycles, then back to 0 -> IN_DATA stays 0, in_changed stays 0.
6. Assert reset for 1 cycle with out_valid=1 and a debounce count in progress -> all outputs and STATUS return to 0, and rdata at 0x84 = 0.
